axi_10g_tx_frame_fifo: RTL and testbench

AXI_10G_TX_FRAME_FIFO -- requirements
Module: axi_10g_tx_frame_fifo

---
 rtl/axi_10g_tx_frame_fifo_if.sv | 16 +
 rtl/axi_10g_tx_frame_fifo.sv | 150 +++++++++++++++
 tb/tb_axi_10g_tx_frame_fifo.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_10g_tx_frame_fifo_if.sv
// AXI4-Stream beat bundle (64-bit data, byte keep, last) shared by the TX frame FIFO ports.
// The master drives the payload and the slave returns tready.
interface axi_10g_tx_frame_fifo_if #(
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axi_10g_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: frames become readable only once their tlast beat is written;
// a frame that cannot fit is rewound to the last commit point, dropped and counted.
module axi_10g_tx_frame_fifo #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axi_10g_tx_frame_fifo_if.slave   s_axis,
    axi_10g_tx_frame_fifo_if.master  m_axis,
    output logic [ADDR_W:0]          fifo_level,
    output logic [CNT_W-1:0]         frames_dropped,
    output logic                     overflow_pulse
);
    localparam int unsigned PTR_W   = ADDR_W + 1;
    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned KEEP_W  = 8;
    localparam int unsigned ENTRY_W = 1 + KEEP_W + DATA_W;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FRAME = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_t;

    wr_state_t          wr_state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_commit;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] ram_q;
    logic               ram_valid;

    logic               full_c;
    logic               wr_en_c;
    logic [PTR_W-1:0]   wr_ptr_nxt_c;
    logic [ENTRY_W-1:0] din_c;
    logic               out_ready_c;
    logic               load_out_c;
    logic               rd_en_c;
    logic [PTR_W-1:0]   rd_ptr_nxt_c;

    // Every offered beat is taken; overflow is handled by dropping the frame.
    assign s_axis.tready = 1'b1;

    // Occupancy uses the pre-read rd_ptr, so a same-cycle read never frees space early.
    assign full_c  = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
    assign wr_en_c = s_axis.tvalid && (wr_state != WR_DROP) && !full_c;
    assign din_c   = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

    always_comb begin
        wr_ptr_nxt_c = wr_ptr;
        if (s_axis.tvalid && (wr_state != WR_DROP)) begin
            wr_ptr_nxt_c = full_c ? wr_commit : wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en_c) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din_c;
        end
    end

    // Write-side frame FSM: commit on tlast, rewind and count on overflow.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state       <= WR_IDLE;
            wr_ptr         <= '0;
            wr_commit      <= '0;
            overflow_pulse <= 1'b0;
            frames_dropped <= '0;
        end else begin
            overflow_pulse <= 1'b0;
            wr_ptr         <= wr_ptr_nxt_c;
            case (wr_state)
                WR_IDLE, WR_FRAME: begin
                    if (s_axis.tvalid) begin
                        if (full_c) begin
                            overflow_pulse <= 1'b1;
                            if (frames_dropped != '1) begin
                                frames_dropped <= frames_dropped + CNT_W'(1);
                            end
                            wr_state <= s_axis.tlast ? WR_IDLE : WR_DROP;
                        end else if (s_axis.tlast) begin
                            wr_commit <= wr_ptr + PTR_W'(1);
                            wr_state  <= WR_IDLE;
                        end else begin
                            wr_state <= WR_FRAME;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis.tvalid && s_axis.tlast) begin
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Two-stage read: RAM output register feeds the output register; a RAM read is only
    // issued when its result has somewhere to go, so a tready drop never loses a beat.
    assign out_ready_c  = !m_axis.tvalid || m_axis.tready;
    assign load_out_c   = ram_valid && out_ready_c;
    assign rd_en_c      = (rd_ptr != wr_commit) && (!ram_valid || load_out_c);
    assign rd_ptr_nxt_c = rd_ptr + PTR_W'(rd_en_c);

    always_ff @(posedge aclk) begin
        if (rd_en_c) begin
            ram_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr        <= '0;
            ram_valid     <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tkeep  <= '0;
            m_axis.tdata  <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt_c;
            if (rd_en_c) begin
                ram_valid <= 1'b1;
            end else if (load_out_c) begin
                ram_valid <= 1'b0;
            end
            if (load_out_c) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tlast  <= ram_q[ENTRY_W-1];
                m_axis.tkeep  <= ram_q[DATA_W +: KEEP_W];
                m_axis.tdata  <= ram_q[DATA_W-1:0];
            end else if (m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
        end
    end

    // Level counts committed and uncommitted beats still held in the RAM.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fifo_level <= '0;
        end else begin
            fifo_level <= wr_ptr_nxt_c - rd_ptr_nxt_c;
        end
    end
endmodule

// File: tb/tb_axi_10g_tx_frame_fifo.sv
// Directed bench for the TX frame FIFO: latency, backpressure, overflow drop,
// wrap-around, mid-frame reset and drop-counter saturation.
module tb_axi_10g_tx_frame_fifo;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 2;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    logic              aclk    = 1'b0;
    logic              aresetn = 1'b0;
    logic [ADDR_W:0]   fifo_level;
    logic [CNT_W-1:0]  frames_dropped;
    logic              overflow_pulse;

    axi_10g_tx_frame_fifo_if s_axis ();
    axi_10g_tx_frame_fifo_if m_axis ();

    axi_10g_tx_frame_fifo #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis         (s_axis),
        .m_axis         (m_axis),
        .fifo_level     (fifo_level),
        .frames_dropped (frames_dropped),
        .overflow_pulse (overflow_pulse)
    );

    always #5 aclk = ~aclk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    pulse_cnt = 0;
    beat_t cap_q[$];
    int    cap_cyc[$];
    logic  stall_prev = 1'b0;
    beat_t stall_beat;
    beat_t cur;

    always @(posedge aclk) cyc++;

    // Output monitor: records handshakes, counts pulses, checks hold-while-stalled.
    always @(negedge aclk) begin
        cur = beat_t'({m_axis.tlast, m_axis.tkeep, m_axis.tdata});
        if (aresetn) begin
            if (stall_prev) begin
                checks++;
                if (m_axis.tvalid !== 1'b1 || cur !== stall_beat) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, expected valid=1 beat=%h",
                             m_axis.tvalid, cur, stall_beat);
                end
            end
            if (m_axis.tvalid && m_axis.tready) begin
                cap_q.push_back(cur);
                cap_cyc.push_back(cyc);
            end
            if (overflow_pulse) pulse_cnt++;
            stall_prev = m_axis.tvalid && !m_axis.tready;
            stall_beat = cur;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tvalid = 1'b1;
        @(posedge aclk); #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis.tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        cap_q.delete();
        cap_cyc.delete();
        pulse_cnt = 0;
    endtask

    task automatic wait_cap(input int n, input int budget);
        for (int c = 0; c < budget && cap_q.size() < n; c++) begin
            @(posedge aclk); #1;
        end
        repeat (4) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge aclk);
        @(negedge aclk);
        checks += 7;
        if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", m_axis.tvalid); end
        if (m_axis.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b expected 0", m_axis.tlast); end
        if (m_axis.tdata !== 64'h0) begin errors++; $display("FAIL rst_tdata: got %h expected 0", m_axis.tdata); end
        if (m_axis.tkeep !== 8'h0) begin errors++; $display("FAIL rst_tkeep: got %h expected 0", m_axis.tkeep); end
        if (fifo_level !== '0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        if (frames_dropped !== '0) begin errors++; $display("FAIL rst_dropped: got %0d expected 0", frames_dropped); end
        if (overflow_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse: got %b expected 0", overflow_pulse); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_single_frame();
        logic [63:0] d[3];
        logic [7:0]  k[3];
        d[0] = 64'h1111_1111_1111_1111; k[0] = 8'hFF;
        d[1] = 64'h2222_2222_2222_2222; k[1] = 8'hFF;
        d[2] = 64'h3333_3333_3333_3333; k[2] = 8'h0F;
        m_axis.tready = 1'b1;
        cap_q.delete();
        for (int i = 0; i < 3; i++) begin
            s_axis.tdata = d[i]; s_axis.tkeep = k[i];
            s_axis.tlast = (i == 2); s_axis.tvalid = 1'b1;
            @(negedge aclk);
            checks++;
            if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL store_fwd beat%0d: got tvalid=%b expected 0", i, m_axis.tvalid); end
            @(posedge aclk); #1;
        end
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            checks++;
            if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL latency_t%0d: got tvalid=%b expected 0", i + 1, m_axis.tvalid); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checks++;
            if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== d[i] || m_axis.tkeep !== k[i] || m_axis.tlast !== (i == 2)) begin
                errors++;
                $display("FAIL single_beat%0d: got v=%b d=%h k=%h l=%b expected v=1 d=%h k=%h l=%b",
                         i, m_axis.tvalid, m_axis.tdata, m_axis.tkeep, m_axis.tlast, d[i], k[i], i == 2);
            end
        end
        @(negedge aclk);
        checks++;
        if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL single_end: got tvalid=%b expected 0", m_axis.tvalid); end
        @(posedge aclk); #1;
    endtask

    task automatic test_backpressure();
        int pat[4] = '{1, 0, 0, 1};
        beat_t exp;
        m_axis.tready = 1'b0;
        cap_q.delete();
        for (int i = 0; i < 8; i++)
            send_beat(64'hBEEF_0000_0000_0000 | 64'(i), (i == 7) ? 8'h00 : 8'hFF, i == 7);
        for (int c = 0; c < 64 && cap_q.size() < 8; c++) begin
            m_axis.tready = pat[c % 4][0];
            @(posedge aclk); #1;
        end
        m_axis.tready = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        checks++;
        if (cap_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d beats expected 8", cap_q.size()); end
        for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
            exp = '{last: (i == 7), keep: (i == 7) ? 8'h00 : 8'hFF, data: 64'hBEEF_0000_0000_0000 | 64'(i)};
            checks++;
            if (cap_q[i] !== exp) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, cap_q[i], exp); end
        end
        m_axis.tready = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_overflow();
        beat_t exp;
        m_axis.tready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) send_beat(64'hA000 + 64'(i), 8'hFF, i == 9);
        for (int i = 0; i < 10; i++) send_beat(64'hB000 + 64'(i), 8'hFF, i == 9);
        @(posedge aclk); #1;
        checks += 2;
        if (pulse_cnt != 1) begin errors++; $display("FAIL ovf_pulse: got %0d pulses expected 1", pulse_cnt); end
        if (frames_dropped !== 2'd1) begin errors++; $display("FAIL ovf_dropped: got %0d expected 1", frames_dropped); end
        m_axis.tready = 1'b1;
        wait_cap(10, 40);
        checks++;
        if (cap_q.size() != 10) begin errors++; $display("FAIL ovf_count: got %0d beats expected 10", cap_q.size()); end
        for (int i = 0; i < 10 && i < cap_q.size(); i++) begin
            exp = '{last: (i == 9), keep: 8'hFF, data: 64'hA000 + 64'(i)};
            checks++;
            if (cap_q[i] !== exp) begin errors++; $display("FAIL ovf_beat%0d: got %h expected %h", i, cap_q[i], exp); end
        end
        checks++;
        if (fifo_level !== '0) begin errors++; $display("FAIL ovf_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_wrap();
        beat_t exp;
        int    bad = 0;
        m_axis.tready = 1'b1;
        do_reset();
        for (int f = 0; f < 40; f++)
            for (int b = 0; b < 5; b++)
                send_beat(64'hC0DE_0000_0000_0000 | 64'(f << 8) | 64'(b), 8'(8'hFF >> b), b == 4);
        wait_cap(200, 40);
        checks++;
        if (cap_q.size() != 200) begin errors++; $display("FAIL wrap_count: got %0d beats expected 200", cap_q.size()); end
        for (int n = 0; n < 200 && n < cap_q.size(); n++) begin
            exp = '{last: (n % 5 == 4), keep: 8'(8'hFF >> (n % 5)),
                    data: 64'hC0DE_0000_0000_0000 | 64'((n / 5) << 8) | 64'(n % 5)};
            checks++;
            if (cap_q[n] !== exp) begin
                errors++;
                if (bad++ < 4) $display("FAIL wrap_beat%0d: got %h expected %h", n, cap_q[n], exp);
            end
        end
        if (cap_cyc.size() == 200) begin
            checks++;
            if (cap_cyc[199] - cap_cyc[0] != 199) begin
                errors++;
                $display("FAIL wrap_bubbles: got span %0d cycles expected 199", cap_cyc[199] - cap_cyc[0]);
            end
        end
        checks += 3;
        if (frames_dropped !== '0) begin errors++; $display("FAIL wrap_dropped: got %0d expected 0", frames_dropped); end
        if (pulse_cnt != 0) begin errors++; $display("FAIL wrap_pulse: got %0d expected 0", pulse_cnt); end
        if (fifo_level !== '0) begin errors++; $display("FAIL wrap_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_reset_mid_frame();
        beat_t exp;
        m_axis.tready = 1'b1;
        cap_q.delete();
        send_beat(64'hD0, 8'hFF, 1'b0);
        send_beat(64'hD1, 8'hFF, 1'b0);
        s_axis.tdata = 64'hD2; s_axis.tkeep = 8'hFF; s_axis.tlast = 1'b0; s_axis.tvalid = 1'b1;
        aresetn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            checks++;
            if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== 64'h0 || m_axis.tkeep !== 8'h0 || m_axis.tlast !== 1'b0 ||
                fifo_level !== '0 || frames_dropped !== '0 || overflow_pulse !== 1'b0) begin
                errors++;
                $display("FAIL midrst_out%0d: got v=%b d=%h k=%h l=%b lvl=%0d drop=%0d p=%b expected all 0", c,
                         m_axis.tvalid, m_axis.tdata, m_axis.tkeep, m_axis.tlast, fifo_level, frames_dropped, overflow_pulse);
            end
            @(posedge aclk); #1;
        end
        s_axis.tvalid = 1'b0;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        send_beat(64'hE0, 8'hFF, 1'b0);
        send_beat(64'hE1, 8'h3F, 1'b1);
        wait_cap(2, 20);
        checks += 2;
        if (cap_q.size() != 2) begin errors++; $display("FAIL midrst_count: got %0d beats expected 2", cap_q.size()); end
        if (frames_dropped !== '0) begin errors++; $display("FAIL midrst_dropped: got %0d expected 0", frames_dropped); end
        for (int i = 0; i < 2 && i < cap_q.size(); i++) begin
            exp = '{last: (i == 1), keep: (i == 1) ? 8'h3F : 8'hFF, data: 64'hE0 + 64'(i)};
            checks++;
            if (cap_q[i] !== exp) begin errors++; $display("FAIL midrst_beat%0d: got %h expected %h", i, cap_q[i], exp); end
        end
    endtask

    task automatic test_saturation();
        int len;
        int exp_cnt;
        m_axis.tready = 1'b0;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            len = (k % 2 == 1) ? 20 : 17;
            for (int i = 0; i < len; i++) send_beat(64'hF000 + 64'(i), 8'hFF, i == len - 1);
            @(negedge aclk);
            exp_cnt = (k + 1 > 3) ? 3 : k + 1;
            checks++;
            if (frames_dropped !== CNT_W'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_dropped%0d: got %0d expected %0d", k, frames_dropped, exp_cnt);
            end
            @(posedge aclk); #1;
        end
        checks += 3;
        if (pulse_cnt != 7) begin errors++; $display("FAIL sat_pulse: got %0d pulses expected 7", pulse_cnt); end
        if (fifo_level !== '0) begin errors++; $display("FAIL sat_level: got %0d expected 0", fifo_level); end
        if (cap_q.size() != 0) begin errors++; $display("FAIL sat_output: got %0d beats expected 0", cap_q.size()); end
    endtask

    initial begin
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_wrap();
        test_reset_mid_frame();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
